// File: rtl/hog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hog_pkg
// Purpose  : Shared types for the hog neighbourhood streamer.
// Revision : 1.0 - initial release
// ============================================================================
package hog_pkg;

    localparam int HOG_PIX_W = 8;

    typedef struct packed {
        logic [HOG_PIX_W-1:0] top;
        logic [HOG_PIX_W-1:0] bot;
        logic [HOG_PIX_W-1:0] left;
        logic [HOG_PIX_W-1:0] right;
    } nbr_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pix_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : pix_delay_line
// Purpose  : DEPTH-entry pixel shift register exposing the three neighbour
//            taps {top, left, right} at depths DEPTH, DEPTH/2+1, DEPTH/2-1.
// Revision : 1.0 - initial release
// ============================================================================
module pix_delay_line #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [PIX_W-1:0]      din,
    output logic [2:0][PIX_W-1:0] taps
);

    logic [DEPTH-1:0][PIX_W-1:0] r_sr;

    // Contents are deliberately not reset; the top level never emits stale taps.
    always_ff @(posedge clk) begin
        if (en) begin
            r_sr <= {r_sr[DEPTH-2:0], din};
        end
    end

    assign taps = {r_sr[DEPTH-1], r_sr[DEPTH/2], r_sr[DEPTH/2-2]};

endmodule
`default_nettype wire

// File: rtl/hog_nbr_gen.sv
`default_nettype none
// ============================================================================
// Module   : hog_nbr_gen
// Purpose  : Raster stream to {top, bot, left, right} neighbour words for hog.
//            Define HOG_ZERO_PAD_EN for zero-padded borders with a line flush.
// Revision : 1.0 - initial release
// ============================================================================
module hog_nbr_gen
    import hog_pkg::*;
#(
    parameter int PIX_W = HOG_PIX_W,
    parameter int IMG_W = 64,
    parameter int IMG_H = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [PIX_W-1:0]   i_pix,
    output logic               i_ready,
    output logic               o_valid,
    output logic [4*PIX_W-1:0] o_data
);

    localparam int c_CW    = $clog2(IMG_W);
    localparam int c_RW    = $clog2(IMG_H);
    localparam int c_DEPTH = 2 * IMG_W;
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);

    logic [c_CW-1:0]          r_col;
    logic [c_RW-1:0]          r_row;
    logic                     r_valid;
    logic [4*PIX_W-1:0]       r_data;
    logic                     w_accept;
    logic                     w_shift;
    logic                     w_emit;
    logic                     w_col_last;
    logic                     w_row_last;
    logic [PIX_W-1:0]         w_din;
    logic [PIX_W-1:0]         w_top;
    logic [PIX_W-1:0]         w_bot;
    logic [PIX_W-1:0]         w_left;
    logic [PIX_W-1:0]         w_right;
    logic [2:0][PIX_W-1:0]    w_taps;

    assign w_accept   = i_valid & i_ready;
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);

    pix_delay_line #(
        .PIX_W (PIX_W),
        .DEPTH (c_DEPTH)
    ) u_delay (
        .clk  (clk),
        .en   (w_shift),
        .din  (w_din),
        .taps (w_taps)
    );

`ifdef HOG_ZERO_PAD_EN
    localparam logic [c_RW-1:0] c_ROW_ONE = c_RW'(1);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FLUSH replays the bottom row's centres using col as its cycle counter.
    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_accept && w_row_last && w_col_last) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                if (w_col_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign i_ready = (r_state == ST_RUN);
    assign w_shift = w_accept | w_flush;
    assign w_din   = w_flush ? '0 : i_pix;
    assign w_emit  = w_flush | (w_accept & (r_row != '0));
    assign w_top   = (r_row == c_ROW_ONE) ? '0 : w_taps[2];
    assign w_bot   = w_din;
    assign w_left  = (r_col == '0) ? '0 : w_taps[1];
    assign w_right = w_col_last ? '0 : w_taps[0];
`else
    localparam logic [c_RW-1:0] c_ROW_FIRST_EMIT = c_RW'(2);

    assign i_ready = 1'b1;
    assign w_shift = w_accept;
    assign w_din   = i_pix;
    assign w_emit  = w_accept && (r_row >= c_ROW_FIRST_EMIT) && (r_col != '0) && !w_col_last;
    assign w_top   = w_taps[2];
    assign w_bot   = i_pix;
    assign w_left  = w_taps[1];
    assign w_right = w_taps[0];
`endif

    // Row only advances on real pixels; flush cycles step col alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_shift) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_accept) begin
                    r_row <= w_row_last ? '0 : r_row + c_RW'(1);
                end
            end else begin
                r_col <= r_col + c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_data <= {w_top, w_bot, w_left, w_right};
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_hog_nbr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hog_nbr_gen
// Purpose  : Self-checking bench for hog_nbr_gen (4x4 and 64x128 instances)
//            against an image-level neighbourhood reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hog_nbr_gen;
    import hog_pkg::*;

    localparam int SW = 4;
    localparam int SH = 4;
    localparam int LW = 64;
    localparam int LH = 128;
`ifdef HOG_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    typedef struct {
        int          ev;
        logic [31:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_iv = 1'b0, l_iv = 1'b0;
    logic [7:0]  s_ip = '0, l_ip = '0;
    logic        s_rdy, l_rdy, s_ov, l_ov;
    logic [31:0] s_od, l_od;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  stim[$];
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    hog_nbr_gen #(.PIX_W(8), .IMG_W(SW), .IMG_H(SH)) dut_s (
        .clk(clk), .rst(rst_n), .i_valid(s_iv), .i_pix(s_ip),
        .i_ready(s_rdy), .o_valid(s_ov), .o_data(s_od)
    );

    hog_nbr_gen #(.PIX_W(8), .IMG_W(LW), .IMG_H(LH)) dut_l (
        .clk(clk), .rst(rst_n), .i_valid(l_iv), .i_pix(l_ip),
        .i_ready(l_rdy), .o_valid(l_ov), .o_data(l_od)
    );

    function automatic int evf_of(input int w, input int h);
        return PAD ? w * h + w : w * h;
    endfunction

    function automatic int count_of(input int w, input int h, input int nf);
        return PAD ? nf * w * h : nf * (w - 2) * (h - 2);
    endfunction

    // Image pixel of frame f, zero outside the frame.
    function automatic logic [7:0] px(input int w, input int h, input int f, input int r, input int c);
        if (r < 0 || r >= h || c < 0 || c >= w) return 8'd0;
        return stim[f * w * h + r * w + c];
    endfunction

    task automatic push_exp(input int ev, input logic [31:0] w);
        exp_t e;
        e.ev = ev;
        e.w  = w;
        exp_q.push_back(e);
    endtask

    // Every centre pixel, its four neighbours, and the stream event that triggers it.
    task automatic model_frame(input int w, input int h, input int f);
        int   r0, r1, c0, c1;
        nbr_t n;
        r0 = PAD ? 0 : 1;
        r1 = PAD ? h - 1 : h - 2;
        c0 = PAD ? 0 : 1;
        c1 = PAD ? w - 1 : w - 2;
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                n.top   = px(w, h, f, r - 1, c);
                n.bot   = px(w, h, f, r + 1, c);
                n.left  = px(w, h, f, r, c - 1);
                n.right = px(w, h, f, r, c + 1);
                push_exp(f * evf_of(w, h) + (r + 1) * w + c, n);
            end
        end
    endtask

    task automatic run_stream(input int sel, input int nframes, input int bubble_pct,
                              input int want_cnt, input string name);
        int          w, h, evf, total, ev, prev_ev, cycles, nvalid, loc, budget;
        logic        v, r, exp_rdy;
        logic [31:0] d;
        w       = sel ? LW : SW;
        h       = sel ? LH : SH;
        evf     = evf_of(w, h);
        total   = nframes * evf;
        budget  = total * 4 + 200;
        ev      = 0;
        prev_ev = -1;
        cycles  = 0;
        nvalid  = 0;
        while (1) begin
            @(negedge clk);
            v = sel ? l_ov : s_ov;
            d = sel ? l_od : s_od;
            r = sel ? l_rdy : s_rdy;
            if (v === 1'b1) nvalid++;
            n_cmp++;
            if (prev_ev >= 0 && exp_q.size() > 0 && exp_q[0].ev == prev_ev) begin
                if (v !== 1'b1 || d !== exp_q[0].w) begin
                    n_bad++;
                    $display("FAIL %s out ev=%0d: got valid=%b data=%h, want valid=1 data=%h",
                             name, prev_ev, v, d, exp_q[0].w);
                end
                void'(exp_q.pop_front());
            end else if (v !== 1'b0) begin
                n_bad++;
                $display("FAIL %s spurious ev=%0d: got valid=%b data=%h, want valid=0",
                         name, prev_ev, v, d);
            end
            loc     = ev % evf;
            exp_rdy = (loc < w * h);
            n_cmp++;
            if (r !== exp_rdy) begin
                n_bad++;
                $display("FAIL %s i_ready ev=%0d: got %b, want %b", name, ev, r, exp_rdy);
            end
            if (ev >= total) begin
                if (sel) l_iv = 1'b0; else s_iv = 1'b0;
                break;
            end
            if (!exp_rdy) begin
                if (sel) begin l_iv = 1'($urandom_range(0, 1)); l_ip = 8'($urandom); end
                else     begin s_iv = 1'($urandom_range(0, 1)); s_ip = 8'($urandom); end
                prev_ev = ev;
                ev++;
            end else if (int'($urandom_range(0, 99)) < bubble_pct) begin
                if (sel) begin l_iv = 1'b0; l_ip = 8'($urandom); end
                else     begin s_iv = 1'b0; s_ip = 8'($urandom); end
                prev_ev = -1;
            end else begin
                if (sel) begin l_iv = 1'b1; l_ip = stim[(ev / evf) * w * h + loc]; end
                else     begin s_iv = 1'b1; s_ip = stim[(ev / evf) * w * h + loc]; end
                prev_ev = ev;
                ev++;
            end
            cycles++;
            if (cycles > budget) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s timeout: got %0d events, want %0d", name, ev, total);
                if (sel) l_iv = 1'b0; else s_iv = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (nvalid != want_cnt || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s count: got %0d outputs (%0d unmatched), want %0d",
                     name, nvalid, exp_q.size(), want_cnt);
        end
        exp_q.delete();
    endtask

    task automatic fill_ramp(input int nframes);
        stim.delete();
        for (int i = 0; i < nframes * SW * SH; i++) stim.push_back(8'(i + 1));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp += 6;
        if (s_ov !== 1'b0) begin n_bad++; $display("FAIL reset s_o_valid: got %b, want 0", s_ov); end
        if (s_od !== 32'h0) begin n_bad++; $display("FAIL reset s_o_data: got %h, want 0", s_od); end
        if (s_rdy !== 1'b1) begin n_bad++; $display("FAIL reset s_i_ready: got %b, want 1", s_rdy); end
        if (l_ov !== 1'b0) begin n_bad++; $display("FAIL reset l_o_valid: got %b, want 0", l_ov); end
        if (l_od !== 32'h0) begin n_bad++; $display("FAIL reset l_o_data: got %h, want 0", l_od); end
        if (l_rdy !== 1'b1) begin n_bad++; $display("FAIL reset l_i_ready: got %b, want 1", l_rdy); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        fill_ramp(1);
`ifdef HOG_ZERO_PAD_EN
        model_frame(SW, SH, 0);
`else
        push_exp(9,  32'h020A0507);
        push_exp(10, 32'h030B0608);
        push_exp(13, 32'h060E090B);
        push_exp(14, 32'h070F0A0C);
`endif
        run_stream(0, 1, 0, count_of(SW, SH, 1), "directed");
    endtask

    task automatic test_bubbles();
        fill_ramp(1);
        model_frame(SW, SH, 0);
        run_stream(0, 1, 40, count_of(SW, SH, 1), "bubbles");
    endtask

    task automatic test_back_to_back();
        fill_ramp(2);
        model_frame(SW, SH, 0);
        model_frame(SW, SH, 1);
        run_stream(0, 2, 0, count_of(SW, SH, 2), "back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            s_iv = 1'b1;
            s_ip = 8'($urandom);
        end
        @(negedge clk);
        s_iv  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp += 3;
        if (s_ov !== 1'b0) begin n_bad++; $display("FAIL midreset o_valid: got %b, want 0", s_ov); end
        if (s_od !== 32'h0) begin n_bad++; $display("FAIL midreset o_data: got %h, want 0", s_od); end
        if (s_rdy !== 1'b1) begin n_bad++; $display("FAIL midreset i_ready: got %b, want 1", s_rdy); end
        rst_n = 1'b1;
        fill_ramp(1);
        model_frame(SW, SH, 0);
        run_stream(0, 1, 25, count_of(SW, SH, 1), "after_reset");
    endtask

    task automatic test_large_random();
        stim.delete();
        for (int i = 0; i < LW * LH; i++) stim.push_back(8'($urandom));
        model_frame(LW, LH, 0);
        run_stream(1, 1, 10, count_of(LW, LH, 1), "large_random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bubbles();
        test_back_to_back();
        test_reset_mid_frame();
        test_large_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
